// File: rtl/ac_pkg.sv
// Shared types and constants for the strip dispatcher: FSM encoding,
// error-bit positions and the counter-width helper.
package ac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        RUN,
        DRAIN,
        DONE
    } ac_state_e;

    localparam int ERR_LINE = 0;
    localparam int ERR_SOF  = 1;

    // Counters never collapse to zero width, even for a single lane or strip.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_SRC_IMG_WIDTH  = 960;
    localparam int DEF_SRC_IMG_HEIGHT = 540;
    localparam int DEF_N_PARALLEL     = 4;
    localparam int DEF_COL_W  = cnt_w(DEF_SRC_IMG_WIDTH);
    localparam int DEF_ROW_W  = cnt_w(DEF_SRC_IMG_HEIGHT);
    localparam int DEF_LANE_W = cnt_w(DEF_N_PARALLEL);
    localparam int DEF_SCOL_W = cnt_w(DEF_SRC_IMG_WIDTH / DEF_N_PARALLEL);

endpackage

// File: rtl/ac_lane_slice.sv
// One-entry hold register feeding a single upsampling lane.
module ac_lane_slice #(
    parameter int PIX_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [PIX_WIDTH-1:0] load_data,
    input  logic                 load_last,
    input  logic                 rready,
    output logic                 rvalid,
    output logic [PIX_WIDTH-1:0] rdata,
    output logic                 rlast
);

    logic                 valid_reg;
    logic [PIX_WIDTH-1:0] data_reg;
    logic                 last_reg;

    // A load wins over a drain, so drain+load in one cycle keeps the entry full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            last_reg  <= load_last;
        end else if (rready) begin
            valid_reg <= 1'b0;
        end
    end

    assign rvalid = valid_reg;
    assign rdata  = data_reg;
    assign rlast  = last_reg;

endmodule

// File: rtl/ac_strip_dispatch.sv
// Splits each source line into N_PARALLEL column strips, one registered
// valid/ready channel per upsampling lane, with frame sequencing and status.
module ac_strip_dispatch
    import ac_pkg::*;
#(
    parameter int PIX_WIDTH      = 24,
    parameter int N_PARALLEL     = 4,
    parameter int SRC_IMG_WIDTH  = 960,
    parameter int SRC_IMG_HEIGHT = 540
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            crf_ac_UPSTART,
    output logic                            ac_crf_processing,
    output logic                            ac_crf_frame_done,
    output logic [1:0]                      ac_crf_err,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [PIX_WIDTH-1:0]            s_axis_tdata,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tuser,
    output logic [N_PARALLEL-1:0]           ac_upsp_rvalid,
    input  logic [N_PARALLEL-1:0]           upsp_ac_rready,
    output logic [N_PARALLEL*PIX_WIDTH-1:0] ac_upsp_rdata,
    output logic [N_PARALLEL-1:0]           ac_upsp_rlast
);

    localparam int STRIP  = SRC_IMG_WIDTH / N_PARALLEL;
    localparam int COL_W  = cnt_w(SRC_IMG_WIDTH);
    localparam int ROW_W  = cnt_w(SRC_IMG_HEIGHT);
    localparam int SCOL_W = cnt_w(STRIP);
    localparam int LANE_W = cnt_w(N_PARALLEL);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SRC_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SRC_IMG_HEIGHT - 1);
    localparam logic [SCOL_W-1:0] SCOL_LAST = SCOL_W'(STRIP - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N_PARALLEL - 1);

    generate
        if (SRC_IMG_WIDTH % N_PARALLEL != 0) begin : g_bad_split
            $fatal(1, "ac_strip_dispatch: N_PARALLEL must divide SRC_IMG_WIDTH");
        end
    endgenerate

    ac_state_e          state_reg;
    logic [COL_W-1:0]   col_reg;
    logic [ROW_W-1:0]   row_reg;
    logic [SCOL_W-1:0]  scol_reg;
    logic [LANE_W-1:0]  lane_reg;
    logic               processing_reg;
    logic               frame_done_reg;
    logic [1:0]         err_reg;

    logic                  tready;
    logic                  in_hs;
    logic                  accept;
    logic                  at_eol;
    logic                  at_eos;
    logic                  at_eof;
    logic                  drain_done;
    logic [N_PARALLEL-1:0] lane_load;

    always_comb begin
        tready = 1'b0;
        case (state_reg)
            WAIT_SOF: tready = 1'b1;
            RUN:      tready = !ac_upsp_rvalid[lane_reg] || upsp_ac_rready[lane_reg];
            default:  tready = 1'b0;
        endcase
    end

    assign in_hs  = s_axis_tvalid && tready;
    assign accept = in_hs && ((state_reg == RUN) || ((state_reg == WAIT_SOF) && s_axis_tuser));
    assign at_eol = (col_reg == COL_LAST);
    assign at_eos = (scol_reg == SCOL_LAST);
    assign at_eof = at_eol && (row_reg == ROW_LAST);

    // Every lane is empty or emptying this cycle, so the holds are clear after the edge.
    assign drain_done = &(~ac_upsp_rvalid | upsp_ac_rready);

    generate
        for (genvar gi = 0; gi < N_PARALLEL; gi++) begin : g_lane
            assign lane_load[gi] = accept && (lane_reg == LANE_W'(gi));

            ac_lane_slice #(
                .PIX_WIDTH (PIX_WIDTH)
            ) u_slice (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (lane_load[gi]),
                .load_data (s_axis_tdata),
                .load_last (at_eos),
                .rready    (upsp_ac_rready[gi]),
                .rvalid    (ac_upsp_rvalid[gi]),
                .rdata     (ac_upsp_rdata[gi*PIX_WIDTH +: PIX_WIDTH]),
                .rlast     (ac_upsp_rlast[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            scol_reg       <= '0;
            lane_reg       <= '0;
            processing_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            err_reg        <= '0;
        end else begin
            frame_done_reg <= 1'b0;

            if (accept) begin
                // Line position comes from the counters; tlast is only checked.
                if (s_axis_tlast != at_eol)
                    err_reg[ERR_LINE] <= 1'b1;
                if ((state_reg == RUN) && s_axis_tuser)
                    err_reg[ERR_SOF] <= 1'b1;

                if (at_eol) begin
                    col_reg <= '0;
                    row_reg <= at_eof ? '0 : row_reg + ROW_W'(1);
                end else begin
                    col_reg <= col_reg + COL_W'(1);
                end

                if (at_eos) begin
                    scol_reg <= '0;
                    lane_reg <= (lane_reg == LANE_LAST) ? '0 : lane_reg + LANE_W'(1);
                end else begin
                    scol_reg <= scol_reg + SCOL_W'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (crf_ac_UPSTART) begin
                        err_reg        <= '0;
                        processing_reg <= 1'b1;
                        col_reg        <= '0;
                        row_reg        <= '0;
                        scol_reg       <= '0;
                        lane_reg       <= '0;
                        state_reg      <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (accept)
                        state_reg <= at_eof ? DRAIN : RUN;
                end
                RUN: begin
                    if (accept && at_eof)
                        state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (drain_done) begin
                        frame_done_reg <= 1'b1;
                        processing_reg <= 1'b0;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready     = tready;
    assign ac_crf_processing = processing_reg;
    assign ac_crf_frame_done = frame_done_reg;
    assign ac_crf_err        = err_reg;

endmodule
